evolution_scheduler: RTL and testbench

Generation sequencer for the cellular-automaton datapath. It holds the current board register, which is fed to the `Evolution` core's `prev`. It paces generations with a programmable tick divider and commits the core's `next` back into the board once the core's output is known to reflect the current board. It also handles run, pause, single-step, clear and load commands from the UI/control layer, and keeps a generation counter for display.

---
 rtl/evolution_scheduler.sv | 98 +++++++++
 tb/tb_evolution_scheduler.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/evolution_scheduler.sv
// Generation sequencer for the cellular-automaton datapath: owns the board register,
// paces generations and commits Evolution.next once it is known to reflect the board.
module evolution_scheduler #(
    parameter int P_PARAM_N = 5,
    parameter int P_PERIOD  = 25_000_000,
    parameter int P_GEN_W   = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               cmd_start,
    input  logic                               cmd_pause,
    input  logic                               cmd_step,
    input  logic                               cmd_clear,
    input  logic                               load_en,
    input  logic [P_PARAM_N*P_PARAM_N*2-1:0]   load_data,
    input  logic [P_PARAM_N*P_PARAM_N*2-1:0]   evo_next,
    input  logic                               evo_done,
    output logic [P_PARAM_N*P_PARAM_N*2-1:0]   board,
    output logic                               running,
    output logic [P_GEN_W-1:0]                 generation,
    output logic                               gen_pulse
);

    localparam int TW = (P_PERIOD > 1) ? $clog2(P_PERIOD) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(P_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, WAIT, SETTLE, COMMIT} state_t;

    state_t        state;
    logic [TW-1:0] tick;
    logic [1:0]    settle_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            board      <= '0;
            generation <= '0;
            running    <= 1'b0;
            gen_pulse  <= 1'b0;
            tick       <= '0;
            settle_cnt <= '0;
        end else begin
            gen_pulse <= 1'b0;
            // Counts cycles since the board last changed; two means evo_next has caught up.
            if (settle_cnt != 2'd2)
                settle_cnt <= settle_cnt + 2'd1;

            if (cmd_clear || load_en) begin
                board      <= cmd_clear ? '0 : load_data;
                generation <= '0;
                running    <= 1'b0;
                state      <= IDLE;
                settle_cnt <= '0;
            end else if (cmd_pause && state != IDLE) begin
                // Abandons any pending commit, including one due this cycle.
                state   <= IDLE;
                running <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (!cmd_pause) begin
                            if (cmd_start) begin
                                state   <= WAIT;
                                running <= 1'b1;
                                tick    <= '0;
                            end else if (cmd_step) begin
                                state <= SETTLE;
                            end
                        end
                    end
                    WAIT: begin
                        if (tick == TICK_LAST)
                            state <= SETTLE;
                        else
                            tick <= tick + TW'(1);
                    end
                    SETTLE: begin
                        if (settle_cnt == 2'd2 && evo_done)
                            state <= COMMIT;
                    end
                    COMMIT: begin
                        board      <= evo_next;
                        generation <= generation + P_GEN_W'(1);
                        gen_pulse  <= 1'b1;
                        settle_cnt <= '0;
                        if (running) begin
                            state <= WAIT;
                            tick  <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_evolution_scheduler.sv
// Randomized self-checking bench for evolution_scheduler, paired with a two-stage
// registered model of the Evolution core that rotates every row left by one cell.
module tb_evolution_scheduler;

    localparam int N  = 5;
    localparam int BW = N * N * 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    // Instance A: P_PERIOD=4, 16-bit generation
    logic a_start, a_pause, a_step, a_clear, a_load, a_done;
    logic [BW-1:0] a_ldata, a_s1, a_next, a_board;
    logic a_running, a_pulse;
    logic [15:0] a_gen;
    // Instance B: P_PERIOD=1, 3-bit generation
    logic b_start, b_pause, b_step, b_clear, b_load, b_done;
    logic [BW-1:0] b_ldata, b_s1, b_next, b_board;
    logic b_running, b_pulse;
    logic [2:0] b_gen;

    int tests = 0;
    int fails = 0;

    evolution_scheduler #(.P_PARAM_N(N), .P_PERIOD(4), .P_GEN_W(16)) dut_a (
        .clk(clk), .rst(rst), .cmd_start(a_start), .cmd_pause(a_pause), .cmd_step(a_step),
        .cmd_clear(a_clear), .load_en(a_load), .load_data(a_ldata), .evo_next(a_next),
        .evo_done(a_done), .board(a_board), .running(a_running), .generation(a_gen),
        .gen_pulse(a_pulse));

    evolution_scheduler #(.P_PARAM_N(N), .P_PERIOD(1), .P_GEN_W(3)) dut_b (
        .clk(clk), .rst(rst), .cmd_start(b_start), .cmd_pause(b_pause), .cmd_step(b_step),
        .cmd_clear(b_clear), .load_en(b_load), .load_data(b_ldata), .evo_next(b_next),
        .evo_done(b_done), .board(b_board), .running(b_running), .generation(b_gen),
        .gen_pulse(b_pulse));

    function automatic logic [BW-1:0] rot(input logic [BW-1:0] x);
        logic [BW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                r[(i*N+j)*2 +: 2] = x[(i*N+((j+1)%N))*2 +: 2];
        return r;
    endfunction

    function automatic logic [BW-1:0] rotn(input logic [BW-1:0] x, input int k);
        logic [BW-1:0] r;
        r = x;
        for (int i = 0; i < k; i++) r = rot(r);
        return r;
    endfunction

    function automatic logic [BW-1:0] rnd();
        logic [63:0] w;
        w = {$urandom, $urandom};
        return w[BW-1:0] | BW'(8);
    endfunction

    // Evolution core model: two register stages from prev to next
    always @(posedge clk) begin
        a_s1 <= rot(a_board); a_next <= a_s1;
        b_s1 <= rot(b_board); b_next <= b_s1;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic load_a(input logic [BW-1:0] d);
        a_ldata = d; a_load = 1'b1; tick(); a_load = 1'b0;
    endtask

    task automatic load_b(input logic [BW-1:0] d);
        b_ldata = d; b_load = 1'b1; tick(); b_load = 1'b0;
    endtask

    task automatic test_reset();
        logic [BW-1:0] d;
        rst = 1'b1;
        wait_n(3);
        tests++;
        if (a_board !== '0 || a_gen !== '0 || a_running !== 1'b0 || a_pulse !== 1'b0) begin
            fails++;
            $display("FAIL reset_init got board=%h gen=%0d run=%b pulse=%b expected all zero",
                     a_board, a_gen, a_running, a_pulse);
        end
        rst = 1'b0;
        tick();
        // Get a nonzero board and generation, then reset mid-WAIT
        d = rnd();
        load_a(d);
        wait_n(3);
        a_step = 1'b1; tick(); a_step = 1'b0;
        wait_n(4);
        tests++;
        if (a_gen !== 16'd1 || a_board !== rot(d)) begin
            fails++;
            $display("FAIL reset_prep got gen=%0d board=%h expected gen=1 board=%h", a_gen, a_board, rot(d));
        end
        a_start = 1'b1; tick(); a_start = 1'b0;
        wait_n(2);
        rst = 1'b1;
        tick();
        tests++;
        if (a_board !== '0 || a_gen !== '0 || a_running !== 1'b0 || a_pulse !== 1'b0) begin
            fails++;
            $display("FAIL reset_midwait got board=%h gen=%0d run=%b pulse=%b expected all zero",
                     a_board, a_gen, a_running, a_pulse);
        end
        tick();
        rst = 1'b0;
        wait_n(8);
        tests++;
        if (a_board !== '0 || a_pulse !== 1'b0 || a_running !== 1'b0) begin
            fails++;
            $display("FAIL reset_quiet got board=%h pulse=%b run=%b expected 0 0 0", a_board, a_pulse, a_running);
        end
    endtask

    task automatic test_step();
        logic [BW-1:0] d;
        for (int r = 0; r < 2; r++) begin
            d = (r == 0) ? BW'(4) : rnd();
            load_a(d);
            wait_n(3);
            a_step = 1'b1; tick(); a_step = 1'b0;
            tests++;
            if (a_pulse !== 1'b0 || a_board !== d) begin
                fails++;
                $display("FAIL step_e0 got pulse=%b board=%h expected 0 %h", a_pulse, a_board, d);
            end
            tick();
            tests++;
            if (a_pulse !== 1'b0 || a_board !== d) begin
                fails++;
                $display("FAIL step_e1 got pulse=%b board=%h expected 0 %h", a_pulse, a_board, d);
            end
            tick();
            tests++;
            if (a_pulse !== 1'b1 || a_board !== rot(d) || a_gen !== 16'd1) begin
                fails++;
                $display("FAIL step_e2 got pulse=%b board=%h gen=%0d expected 1 %h 1",
                         a_pulse, a_board, a_gen, rot(d));
            end
            if (r == 0) begin
                tests++;
                if (a_board !== BW'(1)) begin
                    fails++;
                    $display("FAIL step_bit0 got board=%h expected %h", a_board, BW'(1));
                end
            end
            wait_n(6);
            tests++;
            if (a_pulse !== 1'b0 || a_board !== rot(d) || a_running !== 1'b0 || a_gen !== 16'd1) begin
                fails++;
                $display("FAIL step_idle got pulse=%b board=%h run=%b gen=%0d expected 0 %h 0 1",
                         a_pulse, a_board, a_running, a_gen, rot(d));
            end
        end
    endtask

    task automatic test_done_stall();
        logic [BW-1:0] d;
        int seen;
        d = rnd();
        load_a(d);
        wait_n(3);
        a_done = 1'b0;
        a_step = 1'b1; tick(); a_step = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (a_pulse === 1'b1 || a_board !== d) seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL stall_hold got %0d early-change cycles expected 0", seen);
        end
        a_done = 1'b1;
        tick();
        tests++;
        if (a_pulse !== 1'b0) begin
            fails++;
            $display("FAIL stall_commit_cycle got pulse=%b expected 0", a_pulse);
        end
        tick();
        tests++;
        if (a_pulse !== 1'b1 || a_board !== rot(d)) begin
            fails++;
            $display("FAIL stall_release got pulse=%b board=%h expected 1 %h", a_pulse, a_board, rot(d));
        end
        tick();
    endtask

    task automatic test_free_run();
        logic [BW-1:0] d;
        int cnt, k, extra;
        d = rnd();
        load_a(d);
        wait_n(3);
        a_start = 1'b1; tick(); a_start = 1'b0;
        tests++;
        if (a_running !== 1'b1) begin
            fails++;
            $display("FAIL run_flag got running=%b expected 1", a_running);
        end
        cnt = 0; k = 0;
        for (int c = 0; c < 100 && k < 5; c++) begin
            tick();
            cnt++;
            if (a_pulse === 1'b1) begin
                k++;
                tests++;
                if (cnt != 6 || a_board !== rotn(d, k) || a_gen !== 16'(k)) begin
                    fails++;
                    $display("FAIL run_strobe%0d got interval=%0d board=%h gen=%0d expected 6 %h %0d",
                             k, cnt, a_board, a_gen, rotn(d, k), k);
                end
                cnt = 0;
            end
        end
        tests++;
        if (k != 5 || a_board !== d) begin
            fails++;
            $display("FAIL run_cycle got strobes=%0d board=%h expected 5 %h", k, a_board, d);
        end
        a_pause = 1'b1; tick(); a_pause = 1'b0;
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (a_pulse === 1'b1) extra++;
        end
        tests++;
        if (extra != 0 || a_running !== 1'b0 || a_gen !== 16'd5) begin
            fails++;
            $display("FAIL run_pause got strobes=%0d running=%b gen=%0d expected 0 0 5", extra, a_running, a_gen);
        end
    endtask

    task automatic test_abort();
        logic [BW-1:0] d;
        int seen;
        d = rnd();
        load_a(d);
        wait_n(3);
        a_step = 1'b1; tick(); a_step = 1'b0;
        // now in SETTLE
        a_ldata = rnd(); a_clear = 1'b1; a_load = 1'b1;
        tick();
        a_clear = 1'b0; a_load = 1'b0;
        tests++;
        if (a_board !== '0 || a_gen !== '0 || a_running !== 1'b0 || a_pulse !== 1'b0) begin
            fails++;
            $display("FAIL abort_clear got board=%h gen=%0d run=%b pulse=%b expected 0 0 0 0",
                     a_board, a_gen, a_running, a_pulse);
        end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (a_pulse === 1'b1 || a_board !== '0) seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL abort_idle got %0d changed cycles expected 0", seen);
        end
        // pause in the COMMIT cycle suppresses the commit
        load_a(d);
        wait_n(3);
        a_step = 1'b1; tick(); a_step = 1'b0;
        wait_n(4);
        a_step = 1'b1; tick(); a_step = 1'b0;
        tick();
        a_pause = 1'b1; tick(); a_pause = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (a_pulse === 1'b1) seen++;
            tick();
        end
        tests++;
        if (seen != 0 || a_board !== rot(d) || a_gen !== 16'd1 || a_running !== 1'b0) begin
            fails++;
            $display("FAIL pause_commit got strobes=%0d board=%h gen=%0d run=%b expected 0 %h 1 0",
                     seen, a_board, a_gen, a_running, rot(d));
        end
    endtask

    task automatic test_stale();
        logic [BW-1:0] p0, p1;
        int cnt;
        p0 = rnd();
        p1 = rnd() ^ BW'(2);
        load_b(p0);
        wait_n(5);
        load_b(p1);
        b_step = 1'b1; tick(); b_step = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20 && b_pulse !== 1'b1; i++) begin
            tick();
            cnt++;
        end
        tests++;
        if (b_pulse !== 1'b1 || cnt != 3) begin
            fails++;
            $display("FAIL stale_timing got pulse=%b after %0d cycles expected 1 after 3", b_pulse, cnt);
        end
        tests++;
        if (b_board !== rot(p1) || b_gen !== 3'd1) begin
            fails++;
            $display("FAIL stale_data got board=%h gen=%0d expected %h 1", b_board, b_gen, rot(p1));
        end
        tick();
    endtask

    task automatic test_wrap();
        logic [BW-1:0] d;
        int cnt, k;
        d = rnd();
        load_b(d);
        wait_n(3);
        b_start = 1'b1; tick(); b_start = 1'b0;
        cnt = 0; k = 0;
        for (int c = 0; c < 200 && k < 9; c++) begin
            tick();
            cnt++;
            if (b_pulse === 1'b1) begin
                k++;
                tests++;
                if (cnt != ((k == 1) ? 3 : 4) || b_gen !== 3'(k) || b_board !== rotn(d, k)) begin
                    fails++;
                    $display("FAIL wrap_strobe%0d got interval=%0d gen=%0d board=%h expected %0d %0d %h",
                             k, cnt, b_gen, b_board, (k == 1) ? 3 : 4, k % 8, rotn(d, k));
                end
                cnt = 0;
            end
        end
        tests++;
        if (k != 9) begin
            fails++;
            $display("FAIL wrap_count got strobes=%0d expected 9", k);
        end
        b_pause = 1'b1; tick(); b_pause = 1'b0;
        tests++;
        if (b_running !== 1'b0) begin
            fails++;
            $display("FAIL wrap_pause got running=%b expected 0", b_running);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        {a_start, a_pause, a_step, a_clear, a_load} = '0;
        {b_start, b_pause, b_step, b_clear, b_load} = '0;
        a_done = 1'b1; b_done = 1'b1;
        a_ldata = '0; b_ldata = '0;
        test_reset();
        test_step();
        test_done_stall();
        test_free_run();
        test_abort();
        test_stale();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
